// File: rtl/dcmi_capture.sv
// ---------------------------------------------------------------------------
// dcmi_capture
//   Camera parallel-interface (DCMI style) capture block. Samples the sync and
//   data pins on the pixel clock and recovers frame/line framing, either from
//   the vsync/hsync pins or from embedded FF 00 00 <code> sequences. Pixels
//   are packed into 32-bit words and buffered in a small output FIFO.
//
// Parameters
//   OUT_DEPTH       output FIFO depth in 32-bit words (power of 2, >= 2)
//
// Ports
//   clk             pixel clock, rising edge
//   rstn            asynchronous active-low reset
//   capture_en      capture enable level; a rising edge arms capture
//   snapshot_mode   1 = one frame per arm, 0 = continuous
//   embd_sync_en    1 = embedded sync codes, 0 = vsync/hsync pins
//   vsync_polarity  pin level that means "frame valid"
//   hsync_polarity  pin level that means "line valid"
//   data_bus_width  00 = 8, 01 = 10, 10 = 12, 11 = 14 bits
//   fsc/fec/lsc/lec embedded frame start/end, line start/end code bytes
//   dcmi_vsync      vsync pin
//   dcmi_hsync      hsync pin
//   dcmi_data       pixel data pins
//   out_valid       out_data holds a word (FIFO not empty)
//   out_data        packed pixel word (0 while empty)
//   out_ready       consumer accepts the word when out_valid & out_ready
//   frame_done      one-cycle pulse after the end-of-frame flush
//   ovr_err         one-cycle pulse when a completed word is dropped
//   capture_active  high in WAIT_FS or FRAME
//   line_cnt        lines completed in the current frame
//   dbg_state       main FSM state: 0 IDLE, 1 WAIT_FS, 2 FRAME, 3 FLUSH
//
// Handshake: a word leaves the FIFO on every rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and out_data
// stays stable while out_valid is high and out_ready is low.
// ---------------------------------------------------------------------------
module dcmi_capture #(
    parameter int OUT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        capture_en,
    input  logic        snapshot_mode,
    input  logic        embd_sync_en,
    input  logic        vsync_polarity,
    input  logic        hsync_polarity,
    input  logic [1:0]  data_bus_width,
    input  logic [7:0]  fsc,
    input  logic [7:0]  fec,
    input  logic [7:0]  lsc,
    input  logic [7:0]  lec,
    input  logic        dcmi_vsync,
    input  logic        dcmi_hsync,
    input  logic [13:0] dcmi_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        frame_done,
    output logic        ovr_err,
    output logic        capture_active,
    output logic [13:0] line_cnt,
    output logic [1:0]  dbg_state
);

    localparam int PW = $clog2(OUT_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FS = 2'd1,
        ST_FRAME   = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SD_S0 = 2'd0,
        SD_S1 = 2'd1,
        SD_S2 = 2'd2,
        SD_S3 = 2'd3
    } sync_t;

    state_t      r_state, w_state_nxt;
    sync_t       r_sd, w_sd_nxt;

    // Registered pin copies
    logic        r_vsync, r_hsync;
    logic [13:0] r_data;
    logic        r_cap_en, r_cap_en_d;

    // Configuration, frozen outside IDLE/WAIT_FS
    logic        r_cfg_snap, r_cfg_embd, r_cfg_vpol, r_cfg_hpol;
    logic [1:0]  r_cfg_bw;
    logic [7:0]  r_cfg_fsc, r_cfg_fec, r_cfg_lsc, r_cfg_lec;

    logic        r_fv_d, r_lv_d, r_line_act;
    logic [31:0] r_pack, r_word;
    logic [1:0]  r_lane;
    logic        r_word_vld;
    logic        r_frame_done, r_ovr;
    logic [13:0] r_line_cnt;

    logic [31:0] r_mem [OUT_DEPTH];
    logic [PW:0] r_wptr, r_rptr;

    logic        w_cfg_load, w_cap_rise, w_in_frame;
    logic        w_fv, w_lv;
    logic [7:0]  w_byte;
    logic        w_reserved, w_code;
    logic        w_m_fsc, w_m_fec, w_m_lsc, w_m_lec;
    logic        w_e_fs, w_e_fe, w_e_ls, w_e_le;
    logic        w_frame_start, w_frame_end, w_line_end, w_pix_vld;
    logic [13:0] w_pix;
    logic        w_last_lane;
    logic [31:0] w_pack_ins;
    logic        w_empty, w_full, w_pop, w_push, w_drop;

    // ---------------- pin and config registers ----------------
    // The capture_en history resets high so that an enable held high across
    // reset is not mistaken for a fresh arming edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vsync    <= 1'b0;
            r_hsync    <= 1'b0;
            r_data     <= '0;
            r_cap_en   <= 1'b1;
            r_cap_en_d <= 1'b1;
        end else begin
            r_vsync    <= dcmi_vsync;
            r_hsync    <= dcmi_hsync;
            r_data     <= dcmi_data;
            r_cap_en   <= capture_en;
            r_cap_en_d <= r_cap_en;
        end
    end

    assign w_cfg_load = (r_state == ST_IDLE) || (r_state == ST_WAIT_FS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cfg_snap <= 1'b0;
            r_cfg_embd <= 1'b0;
            r_cfg_vpol <= 1'b0;
            r_cfg_hpol <= 1'b0;
            r_cfg_bw   <= 2'b00;
            r_cfg_fsc  <= '0;
            r_cfg_fec  <= '0;
            r_cfg_lsc  <= '0;
            r_cfg_lec  <= '0;
        end else if (w_cfg_load) begin
            r_cfg_snap <= snapshot_mode;
            r_cfg_embd <= embd_sync_en;
            r_cfg_vpol <= vsync_polarity;
            r_cfg_hpol <= hsync_polarity;
            r_cfg_bw   <= data_bus_width;
            r_cfg_fsc  <= fsc;
            r_cfg_fec  <= fec;
            r_cfg_lsc  <= lsc;
            r_cfg_lec  <= lec;
        end
    end

    // ---------------- framing decode ----------------
    assign w_fv = ~(r_vsync ^ r_cfg_vpol);
    assign w_lv = ~(r_hsync ^ r_cfg_hpol);

    assign w_byte     = r_data[7:0];
    assign w_reserved = (w_byte == 8'h00) || (w_byte == 8'hFF);
    assign w_code     = (r_sd == SD_S3);

    // Code bytes are matched with priority fsc > fec > lsc > lec.
    assign w_m_fsc = (w_byte == r_cfg_fsc);
    assign w_m_fec = (w_byte == r_cfg_fec);
    assign w_m_lsc = (w_byte == r_cfg_lsc);
    assign w_m_lec = (w_byte == r_cfg_lec);
    assign w_e_fs  = w_code & w_m_fsc;
    assign w_e_fe  = w_code & ~w_m_fsc & w_m_fec;
    assign w_e_ls  = w_code & ~w_m_fsc & ~w_m_fec & w_m_lsc;
    assign w_e_le  = w_code & ~w_m_fsc & ~w_m_fec & ~w_m_lsc & w_m_lec;

    always_comb begin
        w_sd_nxt = SD_S0;
        case (r_sd)
            SD_S0:   w_sd_nxt = (w_byte == 8'hFF) ? SD_S1 : SD_S0;
            SD_S1:   w_sd_nxt = (w_byte == 8'h00) ? SD_S2 : SD_S0;
            SD_S2:   w_sd_nxt = (w_byte == 8'h00) ? SD_S3 : SD_S0;
            default: w_sd_nxt = SD_S0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sd       <= SD_S0;
            r_fv_d     <= 1'b0;
            r_lv_d     <= 1'b0;
            r_line_act <= 1'b0;
        end else begin
            r_sd   <= w_sd_nxt;
            r_fv_d <= w_fv;
            r_lv_d <= w_lv;
            if (w_e_fs || w_e_fe || w_e_le) begin
                r_line_act <= 1'b0;
            end else if (w_e_ls) begin
                r_line_act <= 1'b1;
            end
        end
    end

    assign w_in_frame    = (r_state == ST_FRAME);
    assign w_cap_rise    = r_cap_en & ~r_cap_en_d;
    assign w_frame_start = r_cfg_embd ? w_e_fs : (w_fv & ~r_fv_d);
    assign w_frame_end   = r_cfg_embd ? w_e_fe : (~w_fv & r_fv_d);
    assign w_line_end    = r_cfg_embd ? w_e_le : (~w_lv & r_lv_d);
    // The code byte itself (detector in S3) is excluded from the pixel stream.
    assign w_pix_vld     = w_in_frame &
                           (r_cfg_embd ? (r_line_act & ~w_reserved & ~w_code)
                                       : (w_fv & w_lv));

    // ---------------- main FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cap_rise) w_state_nxt = ST_WAIT_FS;
            end
            ST_WAIT_FS: begin
                if (!r_cap_en)          w_state_nxt = ST_IDLE;
                else if (w_frame_start) w_state_nxt = ST_FRAME;
            end
            ST_FRAME: begin
                if (w_frame_end) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_state_nxt = (r_cap_en && !r_cfg_snap) ? ST_WAIT_FS : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- pixel packer ----------------
    always_comb begin
        w_pix = '0;
        case (r_cfg_bw)
            2'b00:   w_pix = {6'b0, r_data[7:0]};
            2'b01:   w_pix = {4'b0, r_data[9:0]};
            2'b10:   w_pix = {2'b0, r_data[11:0]};
            default: w_pix = r_data;
        endcase
    end

    assign w_last_lane = (r_cfg_bw == 2'b00) ? (r_lane == 2'd3) : (r_lane == 2'd1);
    assign w_pack_ins  = (r_cfg_bw == 2'b00)
                       ? (r_pack | ({24'b0, w_pix[7:0]} << {r_lane, 3'b000}))
                       : (r_pack | ({18'b0, w_pix} << {r_lane[0], 4'b0000}));

    // Completed words sit one cycle in r_word before entering the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pack     <= '0;
            r_lane     <= '0;
            r_word     <= '0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= 1'b0;
            if (r_state == ST_FLUSH) begin
                if (r_lane != 2'd0) begin
                    r_word     <= r_pack;
                    r_word_vld <= 1'b1;
                end
                r_pack <= '0;
                r_lane <= '0;
            end else if (w_pix_vld) begin
                if (w_last_lane) begin
                    r_word     <= w_pack_ins;
                    r_word_vld <= 1'b1;
                    r_pack     <= '0;
                    r_lane     <= '0;
                end else begin
                    r_pack <= w_pack_ins;
                    r_lane <= r_lane + 2'd1;
                end
            end
        end
    end

    // ---------------- output FIFO ----------------
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                     (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_pop   = ~w_empty & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = r_word_vld & (~w_full | w_pop);
    assign w_drop  = r_word_vld & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= r_word;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_ovr        <= 1'b0;
            r_frame_done <= 1'b0;
            r_line_cnt   <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_ovr        <= w_drop;
            r_frame_done <= (r_state == ST_FLUSH);
            if ((r_state == ST_WAIT_FS) && w_frame_start) begin
                r_line_cnt <= '0;
            end else if (w_in_frame && w_line_end) begin
                r_line_cnt <= r_line_cnt + 14'd1;
            end
        end
    end

    assign out_valid      = ~w_empty;
    assign out_data       = w_empty ? 32'd0 : r_mem[r_rptr[PW-1:0]];
    assign frame_done     = r_frame_done;
    assign ovr_err        = r_ovr;
    assign capture_active = (r_state == ST_WAIT_FS) || (r_state == ST_FRAME);
    assign line_cnt       = r_line_cnt;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_dcmi_capture.sv
// ---------------------------------------------------------------------------
// tb_dcmi_capture
//   Directed sequence with randomized pixel content for dcmi_capture. A
//   behavioural model turns the list of pixels sent in a frame into the
//   expected packed words; a monitor collects every accepted output word and
//   counts frame_done / ovr_err pulses.
// ---------------------------------------------------------------------------
module tb_dcmi_capture;

    logic        clk = 1'b0;
    logic        rstn;
    logic        capture_en, snapshot_mode, embd_sync_en;
    logic        vsync_polarity, hsync_polarity;
    logic [1:0]  data_bus_width;
    logic [7:0]  fsc, fec, lsc, lec;
    logic        dcmi_vsync, dcmi_hsync;
    logic [13:0] dcmi_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        frame_done, ovr_err, capture_active;
    logic [13:0] line_cnt;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    dcmi_capture #(.OUT_DEPTH(4)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .capture_en     (capture_en),
        .snapshot_mode  (snapshot_mode),
        .embd_sync_en   (embd_sync_en),
        .vsync_polarity (vsync_polarity),
        .hsync_polarity (hsync_polarity),
        .data_bus_width (data_bus_width),
        .fsc            (fsc),
        .fec            (fec),
        .lsc            (lsc),
        .lec            (lec),
        .dcmi_vsync     (dcmi_vsync),
        .dcmi_hsync     (dcmi_hsync),
        .dcmi_data      (dcmi_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .frame_done     (frame_done),
        .ovr_err        (ovr_err),
        .capture_active (capture_active),
        .line_cnt       (line_cnt),
        .dbg_state      (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // monitor-owned
    logic [31:0] got_q[$];
    int          fd_cnt  = 0;
    int          ovr_cnt = 0;

    // model-owned
    logic [31:0] exp_q[$];
    logic [31:0] pix_q[$];
    logic [13:0] src_q[$];
    int          got_base = 0, exp_base = 0, fd_base = 0, ovr_base = 0;
    logic [1:0]  cur_bw = 2'b00;
    logic        cur_vp = 1'b0, cur_hp = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (frame_done) fd_cnt++;
            if (ovr_err)    ovr_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_words(input string tag);
        int ng, ne;
        ng = got_q.size() - got_base;
        ne = exp_q.size() - exp_base;
        chk({tag, "_count"}, 32'(ng), 32'(ne));
        for (int i = 0; i < ng && i < ne; i++)
            chk({tag, "_word"}, got_q[got_base + i], exp_q[exp_base + i]);
        got_base = got_q.size();
        exp_base = exp_q.size();
    endtask

    // ---------------- reference model ----------------
    // Pixel i lands in word i/per at lane i%per; the last word is zero-filled.
    task automatic ref_pack();
        int          per, lbits;
        logic [31:0] mask, w;
        per   = (cur_bw == 2'b00) ? 4 : 2;
        lbits = 32 / per;
        case (cur_bw)
            2'b00:   mask = 32'hFF;
            2'b01:   mask = 32'h3FF;
            2'b10:   mask = 32'hFFF;
            default: mask = 32'h3FFF;
        endcase
        w = 0;
        for (int i = 0; i < pix_q.size(); i++) begin
            w = w | ((pix_q[i] & mask) << ((i % per) * lbits));
            if ((i % per == per - 1) || (i == pix_q.size() - 1)) begin
                exp_q.push_back(w);
                w = 0;
            end
        end
        pix_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit fva, input bit lva, input logic [13:0] d);
        dcmi_vsync = fva ? cur_vp : ~cur_vp;
        dcmi_hsync = lva ? cur_hp : ~cur_hp;
        dcmi_data  = d;
        tick();
    endtask

    task automatic configure(input bit snap, input bit embd, input bit vp,
                             input bit hp, input logic [1:0] bw);
        capture_en = 1'b0;
        repeat (4) tick();
        snapshot_mode  = snap;
        embd_sync_en   = embd;
        vsync_polarity = vp;
        hsync_polarity = hp;
        data_bus_width = bw;
        cur_vp = vp;
        cur_hp = hp;
        cur_bw = bw;
        dcmi_vsync = ~vp;
        dcmi_hsync = ~hp;
        repeat (4) tick();
        capture_en = 1'b1;
        repeat (4) tick();
        fd_base  = fd_cnt;
        ovr_base = ovr_cnt;
    endtask

    task automatic next_pix(output logic [13:0] v);
        if (src_q.size() > 0) v = src_q.pop_front();
        else                  v = 14'($urandom);
    endtask

    task automatic ext_frame(input int lines, input int ppl, input bit model);
        logic [13:0] v;
        repeat (3) drive(1'b0, 1'b0, 14'($urandom));
        repeat (2) drive(1'b1, 1'b0, 14'($urandom));
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < ppl; p++) begin
                next_pix(v);
                if (model) pix_q.push_back({18'b0, v});
                drive(1'b1, 1'b1, v);
            end
            repeat (2) drive(1'b1, 1'b0, 14'($urandom));
        end
        drive(1'b1, 1'b0, 14'($urandom));
        repeat (3) drive(1'b0, 1'b0, 14'($urandom));
        if (model) ref_pack();
    endtask

    task automatic emb_byte(input logic [7:0] b);
        logic [31:0] r;
        r = $urandom;
        dcmi_vsync = 1'b0;
        dcmi_hsync = 1'b0;
        dcmi_data  = {r[5:0], b};
        tick();
    endtask

    task automatic emb_sync(input logic [7:0] code);
        emb_byte(8'hFF);
        emb_byte(8'h00);
        emb_byte(8'h00);
        emb_byte(code);
    endtask

    task automatic emb_fill();
        emb_byte(8'($urandom_range(1, 254)));
    endtask

    task automatic emb_frame(input int lines, input int ppl);
        logic [7:0] b;
        repeat (2) emb_fill();
        emb_sync(fsc);
        emb_fill();
        for (int l = 0; l < lines; l++) begin
            emb_sync(lsc);
            for (int p = 0; p < ppl; p++) begin
                b = 8'($urandom_range(1, 254));
                pix_q.push_back({24'b0, b});
                emb_byte(b);
            end
            emb_sync(lec);
            repeat (2) emb_fill();
        end
        emb_sync(fec);
        repeat (3) emb_fill();
        ref_pack();
    endtask

    task automatic settle();
        repeat (12) tick();
    endtask

    // ---------------- sequence ----------------
    initial begin
        int lines, ppl;
        rstn           = 1'b0;
        capture_en     = 1'b0;
        snapshot_mode  = 1'b0;
        embd_sync_en   = 1'b0;
        vsync_polarity = 1'b0;
        hsync_polarity = 1'b0;
        data_bus_width = 2'b00;
        fsc = 8'h80; fec = 8'h9D; lsc = 8'hC7; lec = 8'hDA;
        dcmi_vsync = 1'b1;
        dcmi_hsync = 1'b1;
        dcmi_data  = '0;
        out_ready  = 1'b1;

        // reset values
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_ovr_err", 32'(ovr_err), 32'd0);
        chk("rst_capture_active", 32'(capture_active), 32'd0);
        chk("rst_line_cnt", 32'(line_cnt), 32'd0);
        rstn = 1'b1;
        repeat (2) tick();

        // external 8-bit, 2 lines x 8 pixels, data 0x01..0x10
        configure(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("arm_capture_active", 32'(capture_active), 32'd1);
        for (int i = 1; i <= 16; i++) src_q.push_back(14'(i));
        ext_frame(2, 8, 1'b0);
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        exp_q.push_back(32'h0C0B0A09);
        exp_q.push_back(32'h100F0E0D);
        settle();
        chk_words("ext8");
        chk("ext8_line_cnt", 32'(line_cnt), 32'd2);
        chk("ext8_frame_done", 32'(fd_cnt - fd_base), 32'd1);

        // external 12-bit, 1 line x 3 pixels, partial word flushed
        configure(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        src_q.push_back(14'hABC);
        src_q.push_back(14'h123);
        src_q.push_back(14'hFFF);
        ext_frame(1, 3, 1'b0);
        exp_q.push_back(32'h01230ABC);
        exp_q.push_back(32'h00000FFF);
        settle();
        chk_words("ext12");
        chk("ext12_frame_done", 32'(fd_cnt - fd_base), 32'd1);

        // randomized external frames
        for (int k = 0; k < 5; k++) begin
            configure(1'b0, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
            lines = $urandom_range(1, 3);
            ppl   = $urandom_range(1, 9);
            ext_frame(lines, ppl, 1'b1);
            settle();
            chk_words("ext_rand");
            chk("ext_rand_line_cnt", 32'(line_cnt), 32'(lines));
            chk("ext_rand_frame_done", 32'(fd_cnt - fd_base), 32'd1);
        end

        // embedded sync, fixed stream
        configure(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        emb_byte(8'h10);
        emb_sync(8'h80);
        emb_sync(8'hC7);
        emb_byte(8'h11); emb_byte(8'h22); emb_byte(8'h33); emb_byte(8'h44);
        emb_sync(8'hDA);
        emb_sync(8'h9D);
        emb_byte(8'h10);
        exp_q.push_back(32'h44332211);
        settle();
        chk_words("emb_fixed");
        chk("emb_fixed_line_cnt", 32'(line_cnt), 32'd1);
        chk("emb_fixed_frame_done", 32'(fd_cnt - fd_base), 32'd1);

        // randomized embedded frames
        for (int k = 0; k < 3; k++) begin
            configure(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
            lines = $urandom_range(1, 3);
            ppl   = $urandom_range(1, 9);
            emb_frame(lines, ppl);
            settle();
            chk_words("emb_rand");
            chk("emb_rand_line_cnt", 32'(line_cnt), 32'(lines));
        end

        // snapshot: second frame ignored
        configure(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        ext_frame(1, 8, 1'b1);
        ext_frame(1, 8, 1'b0);
        settle();
        chk_words("snap");
        chk("snap_frame_done", 32'(fd_cnt - fd_base), 32'd1);
        chk("snap_capture_active", 32'(capture_active), 32'd0);
        chk("snap_state_idle", 32'(dbg_state), 32'd0);

        // overflow: 6 words into a 4-deep FIFO with no consumer
        configure(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        out_ready = 1'b0;
        ext_frame(1, 24, 1'b1);
        settle();
        chk("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'd2);
        chk("ovr_out_valid", 32'(out_valid), 32'd1);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        out_ready = 1'b1;
        settle();
        chk_words("ovr_drain");

        // reset mid-line with buffered words
        configure(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        out_ready = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 14'd0);
        repeat (2) drive(1'b1, 1'b0, 14'd0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 14'(i + 1));
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rstn = 1'b0;
        tick();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
        chk("mid_rst_ovr_err", 32'(ovr_err), 32'd0);
        chk("mid_rst_capture_active", 32'(capture_active), 32'd0);
        chk("mid_rst_line_cnt", 32'(line_cnt), 32'd0);
        rstn = 1'b1;
        out_ready = 1'b1;
        fd_base = fd_cnt;
        repeat (5) drive(1'b1, 1'b1, 14'($urandom));
        repeat (2) drive(1'b1, 1'b0, 14'd0);
        repeat (3) drive(1'b0, 1'b0, 14'd0);
        ext_frame(1, 8, 1'b0);
        settle();
        chk_words("post_rst_no_words");
        chk("post_rst_frame_done", 32'(fd_cnt - fd_base), 32'd0);
        chk("post_rst_capture_active", 32'(capture_active), 32'd0);

        // re-armed after reset, 14-bit
        configure(1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
        ext_frame(2, 5, 1'b1);
        settle();
        chk_words("rearm14");
        chk("rearm14_line_cnt", 32'(line_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
